// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_pkg
// Purpose  : Shared constants and FSM state encodings for the fetch PC generator.
// Revision : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

    localparam logic [31:0] PC_RESET_VEC = 32'h1C00_0000;
    localparam logic [31:0] INST_STEP    = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        IDLE = 2'd2
    } pc_state_e;

endpackage : pc_gen_pkg
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Fetch PC generator with prioritised redirects and optional IDLE
//            low-power wait (IDLE support compiled in by macro PCGEN_IDLE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,
    input  logic        excp_is_tlbr,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_tlbrentry,
    input  logic [31:0] csr_era,
    input  logic        ertn_flush,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        idle_en,
    input  logic        wake_int,
    output logic [31:0] inst_vaddr,
    output logic        inst_addr_valid,
    input  logic        inst_addr_ready,
    output logic [1:0]  pc_state
);

    pc_state_e   r_state;
    logic [31:0] r_pc;
    logic        w_redirect;
    logic        w_fire;
    logic [31:0] w_excp_target;
    logic [31:0] w_target;

    assign w_redirect    = excp_flush | ertn_flush | flush;
    assign w_excp_target = excp_is_tlbr ? csr_tlbrentry : csr_eentry;

    // Exception beats exception-return, which beats a backend flush.
    always_comb begin
        w_target = flush_target;
        if (excp_flush) begin
            w_target = w_excp_target;
        end else if (ertn_flush) begin
            w_target = csr_era;
        end
    end

    // Any redirect this cycle invalidates the address being presented.
    assign inst_addr_valid = (r_state == RUN) && !w_redirect;
    assign w_fire          = inst_addr_valid && inst_addr_ready;
    assign inst_vaddr      = r_pc;
    assign pc_state        = r_state;

`ifndef PCGEN_IDLE_EN
    logic w_unused_idle;
    assign w_unused_idle = idle_en ^ wake_int;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= PC_RESET_VEC;
            r_state <= BOOT;
        end else begin
            case (r_state)
                BOOT: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
`ifdef PCGEN_IDLE_EN
                        // IDLE commits alongside the refetch flush of the next instruction.
                        if (!excp_flush && !ertn_flush && idle_en) begin
                            r_state <= IDLE;
                        end
`endif
                    end else if (w_fire) begin
                        r_pc <= r_pc + INST_STEP;
                    end
                end
`ifdef PCGEN_IDLE_EN
                IDLE: begin
                    if (excp_flush) begin
                        r_pc    <= w_excp_target;
                        r_state <= RUN;
                    end else if (wake_int) begin
                        r_state <= RUN;
                    end
                end
`endif
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

endmodule : pc_gen
`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port excp_flush, input, 1, exception redirect request.
REQ-004 SHALL have port excp_is_tlbr, input, 1, exception is TLB refill; selects csr_tlbrentry.
REQ-005 SHALL have port csr_eentry / csr_tlbrentry / csr_era, input, 32 each, exception entry, refill entry, and return address.
REQ-006 SHALL have port ertn_flush, input, 1, exception-return redirect.
REQ-007 SHALL have port flush, input, 1, backend redirect (branch mispredict or refetch).
REQ-008 SHALL have port flush_target, input, 32, target for flush.
REQ-009 SHALL have port idle_en, input, 1, IDLE instruction committed.
REQ-010 SHALL have port wake_int, input, 1, pending enabled interrupt.
REQ-011 SHALL have port inst_vaddr, output, 32, fetch virtual address to the address-translation stage.
REQ-012 SHALL have port inst_addr_valid, output, 1, inst_vaddr is valid.
REQ-013 SHALL have port inst_addr_ready, input, 1, the translation stage accepts this cycle.
REQ-014 SHALL have port pc_state, output, 2, current FSM state, for debug.

Function
REQ-015 SHALL implement FSM states BOOT=0, RUN=1, IDLE=2.
- BOOT is entered from reset and always moves to RUN after one cycle.
REQ-016 SHALL hold a 32-bit pc register and drive it on inst_vaddr in every state.
REQ-017 SHALL drive inst_addr_valid=1 only in RUN when no redirect input (excp_flush, ertn_flush, flush) is active that cycle; it is combinational from those inputs.
REQ-018 SHALL count a handshake only when inst_addr_valid && inst_addr_ready; on a handshake, pc <= pc+4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
REQ-019 SHALL hold pc and keep valid asserted while ready=0 (no-redirect case).
REQ-020 SHALL apply redirect priority excp_flush > ertn_flush > flush:
- excp_flush target: excp_is_tlbr ? csr_tlbrentry : csr_eentry.
- ertn_flush target: csr_era.
- flush target: flush_target.
REQ-021 SHALL load the redirect target into pc in cycle t+1 for a redirect in cycle t, with inst_addr_valid=1 at t+1 (RUN); redirect latency is 1 cycle.
REQ-022 SHALL apply a redirect arriving together with a handshake instead of the increment; the handshaken address is discarded because the translation stage flushes.
REQ-023 SHALL force pc[1:0] to the incoming target bits unchanged; misalignment is flagged downstream, not here.
REQ-024 SHALL go RUN -> IDLE on idle_en together with flush (the refetch of the instruction after IDLE).
- pc takes flush_target.
- valid=0 while in IDLE.
REQ-025 SHALL go IDLE -> RUN on wake_int, with pc unchanged; excp_flush in IDLE also returns to RUN with the exception target.
REQ-026 SHALL give excp_flush priority over idle_en in the same cycle: the FSM goes to RUN with the exception target.

Reset
REQ-027 SHALL on reset set pc=0x1C000000, state=BOOT, inst_addr_valid=0, pc_state=0.
REQ-028 SHALL give reset priority over all redirects; a reset mid-stall discards the held pc.

Configuration
REQ-029 SHALL compile IDLE support (REQ-024/025) only when macro PCGEN_IDLE_EN is defined.
- Without PCGEN_IDLE_EN: idle_en and wake_int are ignored, the IDLE state is unreachable, and the FSM has BOOT and RUN only.

Structure
REQ-030 SHALL place in the shared defines package:
- the reset vector constant PC_RESET_VEC = 0x1C000000;
- the state encodings BOOT/RUN/IDLE;
- the instruction step constant 4.
REQ-031 SHALL contain no sub-module; the next-pc priority mux is inline logic.

Verification
REQ-032 SHALL cover reset then ready=1 constantly:
- cycle 1 valid=0 (BOOT);
- then addresses 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles.
REQ-033 SHALL cover ready=0 for 3 cycles at pc=0x1C000010: inst_vaddr holds 0x1C000010 with valid=1 throughout, then advances to 0x1C000014 the cycle after ready=1.
REQ-034 SHALL cover excp_flush, ertn_flush and flush in the same cycle with excp_is_tlbr=1, csr_tlbrentry=0x1C001000, csr_era=0x2000, flush_target=0x3000:
- valid=0 that cycle;
- next cycle inst_vaddr=0x1C001000.
REQ-035 SHALL cover flush with flush_target=0x1C000100 during a handshake: next cycle inst_vaddr=0x1C000100, not the pc+4 value.
REQ-036 SHALL cover idle_en with flush_target=0x1C000204 (PCGEN_IDLE_EN defined):
- pc_state=2 and valid=0 until wake_int;
- the cycle after wake_int, valid=1 with inst_vaddr=0x1C000204.
REQ-037 SHALL cover pc=0xFFFFFFFC handshaken: next inst_vaddr=0x00000000.
